// File: rtl/div_seq_pkg.sv
// rtl/div_seq_pkg.sv - shared state codes, widths and aluop codes for the sequential divider
package div_seq_pkg;

  // Default operand width of the integer datapath.
  localparam int DIV_WIDTH = 32;

  // Divider sequencer states, 2-bit encoding.
  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  // Result-ready strobe levels.
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

  // EX-stage aluop codes served by this unit; EX decodes them to start_i/signed_i.
  typedef enum logic [1:0] {
    EXE_DIV  = 2'b00,
    EXE_DIVU = 2'b01,
    EXE_REM  = 2'b10,
    EXE_REMU = 2'b11
  } div_aluop_e;

endpackage

// File: rtl/div_seq_if.sv
// rtl/div_seq_if.sv - request/response bundle between EX stage (master) and divider (slave)
interface div_seq_if
  import div_seq_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);

  logic             start_i;
  logic             signed_i;
  logic [WIDTH-1:0] dividend_i;
  logic [WIDTH-1:0] divisor_i;
  logic             annul_i;
  logic             busy_o;
  logic             ready_o;
  logic [WIDTH-1:0] result_o;
  logic [WIDTH-1:0] rem_o;

  modport master (
    output start_i, signed_i, dividend_i, divisor_i, annul_i,
    input  busy_o, ready_o, result_o, rem_o
  );

  modport slave (
    input  start_i, signed_i, dividend_i, divisor_i, annul_i,
    output busy_o, ready_o, result_o, rem_o
  );

endinterface

// File: rtl/div_seq.sv
// rtl/div_seq.sv - radix-2 restoring divider sequencer (DIV/DIVU/REM/REMU); option DIV_ZERO_FASTPATH_EN
module div_seq
  import div_seq_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic      clk,
  input  logic      rst,
  div_seq_if.slave  bus
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return (~v) + WIDTH'(1);
  endfunction

  // Magnitude is only taken for signed operations with the sign bit set.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? negate(v) : v;
  endfunction

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;     // partial remainder
  logic [WIDTH-1:0] quo_q, quo_d;     // dividend shifted out / quotient shifted in
  logic [WIDTH-1:0] dvsr_q, dvsr_d;   // |divisor|
  logic [WIDTH-1:0] dvnd_q, dvnd_d;   // original dividend bits, for divide-by-zero
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] remo_q, remo_d;
  logic             neg_a_q, neg_a_d;
  logic             neg_b_q, neg_b_d;
  logic             zero_q, zero_d;

  logic [WIDTH:0]   shifted;
  logic             ge;
  logic [WIDTH-1:0] quo_fix, rem_fix;
  logic             ready;

  // One restoring step and the END-state sign fix-up / divide-by-zero override.
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    ge      = (shifted >= {1'b0, dvsr_q});
    quo_fix = (neg_a_q ^ neg_b_q) ? negate(quo_q) : quo_q;
    rem_fix = neg_a_q ? negate(rem_q) : rem_q;
    if (zero_q) begin
      quo_fix = '1;
      rem_fix = dvnd_q;
    end
  end

  // Next-state and datapath update; annul overrides everything outside IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvsr_d  = dvsr_q;
    dvnd_d  = dvnd_q;
    res_d   = res_q;
    remo_d  = remo_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    zero_d  = zero_q;
    case (state_q)
      DIV_FREE: begin
        if (bus.start_i && !bus.annul_i) begin
          neg_a_d = bus.signed_i & bus.dividend_i[WIDTH-1];
          neg_b_d = bus.signed_i & bus.divisor_i[WIDTH-1];
          dvnd_d  = bus.dividend_i;
          quo_d   = magnitude(bus.dividend_i, bus.signed_i);
          dvsr_d  = magnitude(bus.divisor_i, bus.signed_i);
          rem_d   = '0;
          cnt_d   = '0;
          zero_d  = (bus.divisor_i == '0);
`ifdef DIV_ZERO_FASTPATH_EN
          state_d = (bus.divisor_i == '0) ? DIV_BY_ZERO : DIV_ON;
`else
          state_d = DIV_ON;
`endif
        end
      end
      DIV_BY_ZERO: state_d = DIV_END;
      DIV_ON: begin
        rem_d = ge ? (shifted[WIDTH-1:0] - dvsr_q) : shifted[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], ge};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = DIV_END;
      end
      DIV_END: begin
        res_d   = quo_fix;
        remo_d  = rem_fix;
        state_d = DIV_FREE;
      end
      default: state_d = DIV_FREE;
    endcase
    if (bus.annul_i && state_q != DIV_FREE) begin
      state_d = DIV_FREE;
      res_d   = res_q;
      remo_d  = remo_q;
    end
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DIV_FREE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      dvnd_q  <= '0;
      res_q   <= '0;
      remo_q  <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvsr_q  <= dvsr_d;
      dvnd_q  <= dvnd_d;
      res_q   <= res_d;
      remo_q  <= remo_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      zero_q  <= zero_d;
    end
  end

  // Results are presented combinationally during END so they line up with ready_o.
  assign ready        = (state_q == DIV_END) && !bus.annul_i;
  assign bus.ready_o  = ready ? DIV_RESULT_READY : DIV_RESULT_NOT_READY;
  assign bus.busy_o   = (state_q != DIV_FREE);
  assign bus.result_o = ready ? quo_fix : res_q;
  assign bus.rem_o    = ready ? rem_fix : remo_q;

endmodule

// File: tb/tb_div_seq.sv
// tb/tb_div_seq.sv - scoreboard bench for div_seq with random operands and directed corners
module tb_div_seq;

  localparam int W = 32;
`ifdef DIV_ZERO_FASTPATH_EN
  localparam int ZERO_LAT = 2;
`else
  localparam int ZERO_LAT = W + 1;
`endif

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    int           issue;
    int           lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t e_mon;
  logic [W-1:0] last_q = '0;
  logic [W-1:0] last_r = '0;

  div_seq_if #(.WIDTH(W)) bus ();

  div_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: RISC-V division semantics computed with wide signed arithmetic.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sg, input int c);
    exp_t   e;
    longint la, lb;
    e.issue = c;
    e.lat   = (b == 0) ? ZERO_LAT : W + 1;
    if (b == 0) begin
      e.q = '1;
      e.r = a;
    end else if (sg) begin
      la  = longint'($signed(a));
      lb  = longint'($signed(b));
      e.q = W'(la / lb);
      e.r = W'(la % lb);
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  // Monitor: every ready_o pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (bus.ready_o === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: got ready_o=1 expected no pending op (cycle %0d)", cyc);
      end else begin
        e_mon = sb.pop_front();
        chk("quotient", 64'(bus.result_o), 64'(e_mon.q));
        chk("remainder", 64'(bus.rem_o), 64'(e_mon.r));
        chk("latency", 64'(cyc - e_mon.issue), 64'(e_mon.lat));
        last_q = e_mon.q;
        last_r = e_mon.r;
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sg, input bit track);
    @(negedge clk);
    bus.dividend_i = a;
    bus.divisor_i  = b;
    bus.signed_i   = sg;
    bus.start_i    = 1'b1;
    if (track) sb.push_back(model(a, b, sg, cyc));
    @(negedge clk);
    bus.start_i = 1'b0;
  endtask

  task automatic wait_done(output int bc);
    bc = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.busy_o === 1'b1) bc++;
      if (bus.ready_o === 1'b1) return;
      @(negedge clk);
    end
    checks++;
    errors++;
    $display("FAIL ready_timeout: got no ready_o expected within 100 cycles (cycle %0d)", cyc);
  endtask

  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg);
    int bc;
    issue(a, b, sg, 1'b1);
    wait_done(bc);
    chk("busy_cycles", 64'(bc), 64'((b == 0) ? ZERO_LAT : W + 1));
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return '1;
      3:       return W'($urandom_range(0, 20));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    int bc;
    bus.start_i    = 1'b0;
    bus.signed_i   = 1'b0;
    bus.dividend_i = '0;
    bus.divisor_i  = '0;
    bus.annul_i    = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(bus.busy_o), 64'(0));
    chk("reset_ready", 64'(bus.ready_o), 64'(0));
    chk("reset_result", 64'(bus.result_o), 64'(0));
    chk("reset_rem", 64'(bus.rem_o), 64'(0));
    rst = 1'b0;

    run(32'd100, 32'd7, 1'b0);
    run(-32'sd7, 32'd2, 1'b1);
    run(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    run(32'd5, 32'd0, 1'b1);
    run(32'hFFFF_FFF9, 32'd0, 1'b1);
    run(32'h8000_0000, 32'd0, 1'b1);
    run(32'hFFFF_FFFF, 32'd0, 1'b0);
    run(32'hFFFF_FFFF, 32'd1, 1'b0);
    run(32'd7, 32'hFFFF_FFFE, 1'b1);

    // Start while busy is ignored; the original op must complete.
    issue(32'd1000, 32'd3, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    bus.dividend_i = 32'd9;
    bus.divisor_i  = 32'd9;
    bus.start_i    = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    wait_done(bc);

    // Annul at T+10: idle at T+11, no ready, results unchanged.
    issue(32'd12345, 32'd11, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    bus.annul_i = 1'b1;
    @(negedge clk);
    bus.annul_i = 1'b0;
    chk("annul_busy", 64'(bus.busy_o), 64'(0));
    repeat (40) @(negedge clk);
    chk("annul_result", 64'(bus.result_o), 64'(last_q));
    chk("annul_rem", 64'(bus.rem_o), 64'(last_r));

    // Start together with annul in IDLE is not accepted.
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.annul_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    chk("annul_start_busy", 64'(bus.busy_o), 64'(0));
    repeat (40) @(negedge clk);

    // Reset at T+5 clears all outputs the next cycle.
    issue(32'd777, 32'd5, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 64'(bus.busy_o), 64'(0));
    chk("midrst_ready", 64'(bus.ready_o), 64'(0));
    chk("midrst_result", 64'(bus.result_o), 64'(0));
    chk("midrst_rem", 64'(bus.rem_o), 64'(0));
    rst = 1'b0;
    last_q = '0;
    last_r = '0;

    // Back-to-back random traffic.
    for (int i = 0; i < 40; i++) begin
      run(pick(), pick(), 1'($urandom_range(0, 1)));
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
